// File: rtl/cpu_defs.sv
// Shared encodings for the memory stage: memop codes, access FSM states,
// pipeline constants and small decode helpers used by mem_access.
package cpu_defs;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: return off[0];
      OP_LW, OP_SW:         return off != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b0001 << off;
      OP_LH, OP_LHU, OP_SH: return 4'b0011 << off;
      default:              return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] sdata);
    case (op)
      OP_SB:   return {4{sdata[7:0]}};
      OP_SH:   return {2{sdata[15:0]}};
      default: return sdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a little-endian bus word and
// sign- or zero-extends it according to the load type.
module load_align
  import cpu_defs::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'h0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: turns EX/MEM load/store ops into single data-bus transactions,
// stalling the pipeline until ack or timeout, and forms the MEM/WB result.
module mem_access
  import cpu_defs::*;
#(
  parameter logic [7:0] BUS_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mem_wdata,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [3:0]  mem_memop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic [31:0] wb_wdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_req,
  output logic        misalign,
  output logic        bus_err
);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        is_mem;
  logic        is_mis;
  logic        timeout_hit;
  logic [31:0] ld_data;

  assign is_mem      = is_load(mem_memop) || is_store(mem_memop);
  assign is_mis      = is_mem && misaligned(mem_memop, mem_addr[1:0]);
  // Counter holds the number of BUSY cycles already spent; this one is the last allowed.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= {1'b0, BUS_TIMEOUT};

  load_align u_load_align (
    .op   (op_q),
    .off  (off_q),
    .word (rdata_q),
    .data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      op_q      <= OP_NOP;
      off_q     <= 2'b00;
      rdata_q   <= ZeroWord;
      err_q     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= ZeroWord;
      bus_sel   <= 4'h0;
      bus_wdata <= ZeroWord;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_mem && !is_mis) begin
            bus_req   <= 1'b1;
            bus_we    <= is_store(mem_memop) ? WriteEnable : WriteDisable;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= lane_sel(mem_memop, mem_addr[1:0]);
            bus_wdata <= store_lanes(mem_memop, mem_sdata);
            op_q      <= mem_memop;
            off_q     <= mem_addr[1:0];
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            state_q   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (is_load(op_q)) rdata_q <= bus_rdata;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            bus_req <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pipeline-facing outputs: pass-through unless the FSM has something to say.
  always_comb begin
    wb_wdata  = mem_wdata;
    wb_wd     = mem_wd;
    wb_wreg   = mem_wreg;
    stall_req = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_mis) begin
          misalign = 1'b1;
          wb_wreg  = WriteDisable;
        end else if (is_mem) begin
          stall_req = 1'b1;
        end
      end
      ST_BUSY: stall_req = 1'b1;
      ST_DONE: begin
        if (err_q) begin
          bus_err  = 1'b1;
          wb_wreg  = WriteDisable;
          wb_wd    = NOPRegAddr;
          wb_wdata = ZeroWord;
        end else if (is_load(op_q)) begin
          wb_wdata = ld_data;
        end
      end
      default: stall_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected MEM/WB results are queued at issue
// and compared in the DONE cycle; bus fields are checked in the first BUSY cycle.
module tb_mem_access;
  import cpu_defs::*;

  localparam logic [7:0] TMO = 8'd4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mem_wdata, mem_addr, mem_sdata, bus_rdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, bus_ack;
  logic [3:0]  mem_memop;
  logic [31:0] wb_wdata, bus_addr, bus_wdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg, bus_req, bus_we, stall_req, misalign, bus_err;
  logic [3:0]  bus_sel;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  mem_access #(.BUS_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .mem_wdata (mem_wdata),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_memop (mem_memop),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .wb_wdata  (wb_wdata),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .stall_req (stall_req),
    .misalign  (misalign),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * off);
    case (op)
      OP_LB:   return 32'($signed(sh[7:0]));
      OP_LBU:  return sh & 32'h0000_00FF;
      OP_LH:   return 32'($signed(sh[15:0]));
      OP_LHU:  return sh & 32'h0000_FFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_sel(input logic [3:0] op, input logic [1:0] off);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 4'(1 << off);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_bwdata(input logic [3:0] op, input logic [31:0] sd);
    if (op == OP_SB) return {24'h0, sd[7:0]} * 32'h0101_0101;
    if (op == OP_SH) return {16'h0, sd[15:0]} * 32'h0001_0001;
    return sd;
  endfunction

  // Starts just after a rising edge with the DUT in IDLE; ends the same way.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rd, input int wait_n,
                        input bit no_ack, input logic [31:0] exp_wb);
    exp_t e;
    int   n;
    bit   st;
    e.wdata = exp_wb;
    e.wreg  = !no_ack;
    e.err   = no_ack;
    sb.push_back(e);
    st = (op >= OP_SB);
    mem_memop = op; mem_addr = addr; mem_sdata = sd;
    mem_wdata = 32'h1234_5678; mem_wd = 5'd9; mem_wreg = 1'b1;
    #1;
    check_eq({tag, "_stall_idle"}, 32'(stall_req), 32'd1);
    check_eq({tag, "_req_idle"}, 32'(bus_req), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_addr"}, bus_addr, addr & ~32'h3);
    check_eq({tag, "_sel"}, 32'(bus_sel), 32'(model_sel(op, addr[1:0])));
    check_eq({tag, "_we"}, 32'(bus_we), 32'(st));
    if (st) check_eq({tag, "_bwdata"}, bus_wdata, model_bwdata(op, sd));
    n = 0;
    while (stall_req === 1'b1 && n < 300) begin
      check_eq({tag, "_req_busy"}, 32'(bus_req), 32'd1);
      if (!no_ack && n == wait_n) begin
        bus_ack = 1'b1;
        bus_rdata = rd;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_rdata = 32'hA5A5_A5A5;
      n++;
    end
    check_eq({tag, "_busy_cycles"}, 32'(n), no_ack ? 32'(TMO) : 32'(wait_n + 1));
    check_eq({tag, "_req_done"}, 32'(bus_req), 32'd0);
    if (sb.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq({tag, "_wreg"}, 32'(wb_wreg), 32'(e.wreg));
      check_eq({tag, "_err"}, 32'(bus_err), 32'(e.err));
      if (!e.err) begin
        check_eq({tag, "_wdata"}, wb_wdata, e.wdata);
        check_eq({tag, "_wd"}, 32'(wb_wd), 32'd9);
      end
    end
    mem_memop = OP_NOP;
    @(posedge clk); #1;
    check_eq({tag, "_err_idle"}, 32'(bus_err), 32'd0);
    check_eq({tag, "_stall_after"}, 32'(stall_req), 32'd0);
  endtask

  initial begin
    logic [31:0] rdv;
    logic [3:0]  ops[4];
    resetn = 1'b1; mem_memop = OP_NOP; mem_addr = '0; mem_sdata = '0;
    mem_wdata = 32'hCAFE_F00D; mem_wd = 5'd3; mem_wreg = 1'b1;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(bus_req), 32'd0);
    check_eq("rst_we", 32'(bus_we), 32'd0);
    check_eq("rst_addr", bus_addr, 32'h0);
    check_eq("rst_sel", 32'(bus_sel), 32'h0);
    check_eq("rst_bwdata", bus_wdata, 32'h0);
    resetn = 1'b0;
    @(posedge clk); #1;

    check_eq("nop_wdata", wb_wdata, 32'hCAFE_F00D);
    check_eq("nop_wd", 32'(wb_wd), 32'd3);
    check_eq("nop_wreg", 32'(wb_wreg), 32'd1);
    check_eq("nop_stall", 32'(stall_req), 32'd0);
    mem_memop = 4'hC;
    #1;
    check_eq("op12_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    check_eq("op12_req", 32'(bus_req), 32'd0);
    mem_memop = OP_NOP;

    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check_eq("stray_ack_req", 32'(bus_req), 32'd0);
    check_eq("stray_ack_stall", 32'(stall_req), 32'd0);
    check_eq("stray_ack_err", 32'(bus_err), 32'd0);

    run_op("lw_100", OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 32'hDEAD_BEEF);
    run_op("lb_103", OP_LB, 32'h103, 32'h0, 32'h8011_2233, 0, 1'b0, 32'hFFFF_FF80);
    run_op("lbu_103", OP_LBU, 32'h103, 32'h0, 32'h8011_2233, 0, 1'b0, 32'h0000_0080);
    run_op("sh_202", OP_SH, 32'h202, 32'h0000_ABCD, 32'h0, 0, 1'b0, 32'h1234_5678);
    run_op("sb_041", OP_SB, 32'h041, 32'hFFFF_FF3C, 32'h0, 2, 1'b0, 32'h1234_5678);
    run_op("sw_080", OP_SW, 32'h080, 32'h0BAD_F00D, 32'h0, 1, 1'b0, 32'h1234_5678);

    ops[0] = OP_LB; ops[1] = OP_LBU; ops[2] = OP_LH; ops[3] = OP_LHU;
    rdv = 32'h8F7E_EDC5;
    for (int k = 0; k < 4; k++) begin
      for (int off = 0; off < 4; off++) begin
        if (k < 2 || off[0] == 1'b0)
          run_op($sformatf("ld%0d_off%0d", k, off), ops[k], 32'h400 + 32'(off), 32'h0, rdv,
                 off, 1'b0, model_load(ops[k], 2'(off), rdv));
      end
    end

    mem_memop = OP_LW; mem_addr = 32'h101; mem_wreg = 1'b1;
    #1;
    check_eq("mis_flag", 32'(misalign), 32'd1);
    check_eq("mis_wreg", 32'(wb_wreg), 32'd0);
    check_eq("mis_stall", 32'(stall_req), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq("mis_req", 32'(bus_req), 32'd0);
      check_eq("mis_stay", 32'(misalign), 32'd1);
    end
    mem_memop = OP_LH; mem_addr = 32'h203;
    #1;
    check_eq("mis_lh", 32'(misalign), 32'd1);
    mem_memop = OP_NOP;
    #1;
    check_eq("mis_clear", 32'(misalign), 32'd0);

    run_op("timeout", OP_LW, 32'h500, 32'h0, 32'h1111_1111, 0, 1'b1, 32'h0);
    run_op("ack_at_tmo", OP_LW, 32'h504, 32'h0, 32'h2222_3333, int'(TMO) - 1, 1'b0,
           32'h2222_3333);

    mem_memop = OP_SW; mem_addr = 32'h300; mem_sdata = 32'h7777_7777;
    @(posedge clk); #1;
    check_eq("rstmid_req_busy", 32'(bus_req), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;
    mem_memop = OP_NOP;
    check_eq("rstmid_req", 32'(bus_req), 32'd0);
    check_eq("rstmid_we", 32'(bus_we), 32'd0);
    check_eq("rstmid_addr", bus_addr, 32'h0);
    check_eq("rstmid_sel", 32'(bus_sel), 32'h0);
    check_eq("rstmid_bwdata", bus_wdata, 32'h0);
    resetn = 1'b0;
    #1;
    check_eq("rstmid_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    check_eq("rstmid_idle_req", 32'(bus_req), 32'd0);
    check_eq("rstmid_idle_stall", 32'(stall_req), 32'd0);
    run_op("after_rst", OP_LHU, 32'h602, 32'h0, 32'hBEEF_0001, 0, 1'b0, 32'h0000_BEEF);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
